sd_spi_host_cmd: RTL and testbench

SPI-mode SD host command engine: the initiator side of the SD SPI protocol that the emulator core answers. It generates SCK from the system clock and drives CS_n and MOSI. It frames CMDx tokens, polls MISO for the R1 token, collects trailing R3/R7 bytes, and returns the response on a valid/ready-style interface. It sits between a controlling CPU/CSR block and the SD pins, and doubles as bench stimulus for the emulator core.

---
 rtl/sd_spi_host_cmd.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_sd_spi_host_cmd.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_host_cmd.sv
// sd_spi_host_cmd: SPI-mode SD host command engine (mode 0, SCK from sys_clk).
// Frames CMDx tokens, polls R1, collects R3/R7 bytes, returns a response.
// Ports: sys_clk/sys_rst (sync, active-high); init_start, cmd_valid/cmd_ready,
//   cmd_index/cmd_arg/cmd_crc/resp_len in; resp_valid/resp_r1/resp_data/
//   resp_timeout out; spi_sck/spi_cs_n/spi_mosi out, spi_miso in.
// Option: define SD_SPI_HOST_CRC7_EN to compute CRC7 serially (cmd_crc ignored).
module sd_spi_host_cmd #(
  parameter int CLK_DIV = 4,
  parameter int NCR_MAX = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_start,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic [2:0]  resp_len,
  output logic        resp_valid,
  output logic [7:0]  resp_r1,
  output logic [31:0] resp_data,
  output logic        resp_timeout,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [7:0] NCR_LAST = 8'(NCR_MAX - 1);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_INIT = 4'd1;
  localparam logic [3:0] S_PRE  = 4'd2;
  localparam logic [3:0] S_CMD  = 4'd3;
  localparam logic [3:0] S_POLL = 4'd4;
  localparam logic [3:0] S_DATA = 4'd5;
  localparam logic [3:0] S_TAIL = 4'd6;
  localparam logic [3:0] S_HOLD = 4'd7;
  localparam logic [3:0] S_DONE = 4'd8;

  logic [3:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    ph_q, ph_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [47:0]   frame_q, frame_d;
  logic          len4_q, len4_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    r1w_q, r1w_d;
  logic [31:0]   dw_q, dw_d;
  logic          tow_q, tow_d;
  logic          sck_q, sck_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic          rv_q, rv_d;
  logic [7:0]    r1_q, r1_d;
  logic [31:0]   data_q, data_d;
  logic          to_q, to_d;
`ifdef SD_SPI_HOST_CRC7_EN
  logic [6:0]    crc_q, crc_d;
  logic [5:0]    cbit_q, cbit_d;
`endif

  logic active, tick, rise, fall, last, ld_bit;

  // ph_q walks 16 half-bit phases per byte; even phases end in a rise.
  assign active = (state_q != S_IDLE) && (state_q != S_DONE);
  assign tick   = active && (div_q == DIV_LAST);
  assign rise   = tick && !ph_q[0] && (state_q != S_HOLD);
  assign fall   = tick && ph_q[0] && (state_q != S_HOLD);
  assign last   = fall && (ph_q == 4'd15);
  // Next command bit goes out on every fall of CMD, and on the final
  // fall of PRE so bit 47 is set up a half-bit before the first rise.
  assign ld_bit = fall && (((state_q == S_CMD) && !(last && cnt_q == 8'd5))
                        || ((state_q == S_PRE) && last));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    len4_d  = len4_q;
    rx_d    = rx_q;
    r1w_d   = r1w_q;
    dw_d    = dw_q;
    tow_d   = tow_q;
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    rv_d    = 1'b0;
    r1_d    = r1_q;
    data_d  = data_q;
    to_d    = to_q;
`ifdef SD_SPI_HOST_CRC7_EN
    crc_d   = crc_q;
    cbit_d  = cbit_q;
`endif

    if (active) begin
      div_d = tick ? '0 : div_q + DW'(1);
    end
    if (tick) begin
      ph_d = ph_q + 4'd1;
    end
    if (rise) begin
      sck_d = 1'b1;
      rx_d  = {rx_q[6:0], spi_miso};
    end
    if (fall) begin
      sck_d  = 1'b0;
      mosi_d = 1'b1;
    end
    if (ld_bit) begin
      mosi_d  = frame_q[47];
      frame_d = {frame_q[46:0], 1'b0};
`ifdef SD_SPI_HOST_CRC7_EN
      cbit_d = cbit_q + 6'd1;
      if (cbit_q < 6'd40) begin
        crc_d = {crc_q[5:0], 1'b0}
              ^ ({7{frame_q[47] ^ crc_q[6]}} & 7'h09);
      end else if (cbit_q < 6'd47) begin
        mosi_d = crc_q[6];
        crc_d  = {crc_q[5:0], 1'b0};
      end else begin
        mosi_d = 1'b1;
      end
`endif
    end

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        ph_d  = 4'd0;
        cnt_d = 8'd0;
        if (init_start) begin
          state_d = S_INIT;
        end else if (cmd_valid) begin
          state_d = S_PRE;
          cs_n_d  = 1'b0;
          frame_d = {2'b01, cmd_index, cmd_arg, cmd_crc, 1'b1};
          len4_d  = |resp_len;
`ifdef SD_SPI_HOST_CRC7_EN
          crc_d  = 7'd0;
          cbit_d = 6'd0;
`endif
        end
      end
      S_INIT: begin
        if (last) begin
          if (cnt_q == 8'd9) begin
            state_d = S_DONE;
            rv_d    = 1'b1;
            r1_d    = 8'hFF;
            data_d  = 32'd0;
            to_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_PRE: begin
        if (last) begin
          state_d = S_CMD;
          cnt_d   = 8'd0;
        end
      end
      S_CMD: begin
        if (last) begin
          if (cnt_q == 8'd5) begin
            state_d = S_POLL;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_POLL: begin
        // rx_q holds the complete byte during its final phase.
        if (last) begin
          if (!rx_q[7]) begin
            r1w_d   = rx_q;
            tow_d   = 1'b0;
            dw_d    = 32'd0;
            cnt_d   = 8'd0;
            state_d = (len4_q && !rx_q[2]) ? S_DATA : S_TAIL;
          end else if (cnt_q == NCR_LAST) begin
            r1w_d   = 8'hFF;
            tow_d   = 1'b1;
            dw_d    = 32'd0;
            state_d = S_TAIL;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_DATA: begin
        if (last) begin
          dw_d = {dw_q[23:0], rx_q};
          if (cnt_q == 8'd3) begin
            state_d = S_TAIL;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_TAIL: begin
        if (last) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // CS_n held low one more half-bit after the last fall.
        if (tick) begin
          state_d = S_DONE;
          cs_n_d  = 1'b1;
          rv_d    = 1'b1;
          r1_d    = r1w_q;
          data_d  = dw_q;
          to_d    = tow_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      ph_q    <= 4'd0;
      cnt_q   <= 8'd0;
      frame_q <= 48'd0;
      len4_q  <= 1'b0;
      rx_q    <= 8'hFF;
      r1w_q   <= 8'hFF;
      dw_q    <= 32'd0;
      tow_q   <= 1'b0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b1;
      rv_q    <= 1'b0;
      r1_q    <= 8'hFF;
      data_q  <= 32'd0;
      to_q    <= 1'b0;
`ifdef SD_SPI_HOST_CRC7_EN
      crc_q   <= 7'd0;
      cbit_q  <= 6'd0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      len4_q  <= len4_d;
      rx_q    <= rx_d;
      r1w_q   <= r1w_d;
      dw_q    <= dw_d;
      tow_q   <= tow_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      rv_q    <= rv_d;
      r1_q    <= r1_d;
      data_q  <= data_d;
      to_q    <= to_d;
`ifdef SD_SPI_HOST_CRC7_EN
      crc_q   <= crc_d;
      cbit_q  <= cbit_d;
`endif
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign resp_valid   = rv_q;
  assign resp_r1      = r1_q;
  assign resp_data    = data_q;
  assign resp_timeout = to_q;
  assign spi_sck      = sck_q;
  assign spi_cs_n     = cs_n_q;
  assign spi_mosi     = mosi_q;

endmodule

// File: tb/tb_sd_spi_host_cmd.sv
// tb_sd_spi_host_cmd: directed + randomized bench for sd_spi_host_cmd
// with an SD card byte-stream model on MISO and a transaction-level reference.
module tb_sd_spi_host_cmd;
  localparam int CD  = 4;
  localparam int NCR = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        init_start = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic [6:0]  cmd_crc = '0;
  logic [2:0]  resp_len = '0;
  logic        resp_valid;
  logic [7:0]  resp_r1;
  logic [31:0] resp_data;
  logic        resp_timeout;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso = 1'b1;

  sd_spi_host_cmd #(.CLK_DIV(CD), .NCR_MAX(NCR)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_start(init_start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .cmd_crc(cmd_crc), .resp_len(resp_len),
    .resp_valid(resp_valid), .resp_r1(resp_r1), .resp_data(resp_data),
    .resp_timeout(resp_timeout), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  // Card side: bytes returned after the 7 host bytes (PRE + CMD).
  logic [7:0] reply [0:31];
  logic [7:0] mq [$];
  int hi_rises = 0;
  int hi_zero = 0;
  int rcnt = 0;
  int bitc = 0;
  logic [7:0] cur = '0;
  logic psck = 1'b0;
  logic pcs = 1'b1;

  function automatic logic miso_for(input int r);
    logic [7:0] v;
    int b;
    if (r < 56) return 1'b1;
    b = (r - 56) / 8;
    if (b > 31) return 1'b1;
    v = reply[b];
    return v[7 - ((r - 56) % 8)];
  endfunction

  always @(negedge sys_clk) begin
    if (pcs && !spi_cs_n) begin
      mq.delete();
      rcnt = 0;
      bitc = 0;
    end
    if (spi_sck && !psck) begin
      if (spi_cs_n) begin
        hi_rises++;
        if (!spi_mosi) hi_zero++;
      end else begin
        cur = {cur[6:0], spi_mosi};
        bitc++;
        if (bitc == 8) begin
          mq.push_back(cur);
          bitc = 0;
        end
        rcnt++;
      end
    end
    spi_miso = spi_cs_n ? 1'b1 : miso_for(rcnt);
    psck = spi_sck;
    pcs = spi_cs_n;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] m);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = m[i] ^ c[6];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic fill_ff();
    for (int i = 0; i < 32; i++) reply[i] = 8'hFF;
  endtask

  task automatic do_init(input logic with_cmd);
    int h0, z0, lat;
    h0 = hi_rises;
    z0 = hi_zero;
    init_start = 1'b1;
    cmd_valid = with_cmd;
    @(posedge sys_clk);
    #1;
    init_start = 1'b0;
    cmd_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 800) begin
      @(posedge sys_clk);
      #1;
      lat++;
    end
    chk("init_valid", resp_valid, 1'b1);
    chk("init_lat", (lat >= 640 && lat <= 644), 1'b1);
    chk("init_rises", hi_rises - h0, 80);
    chk("init_mosi0", hi_zero - z0, 0);
    chk("init_r1", resp_r1, 8'hFF);
    chk("init_to", resp_timeout, 1'b0);
    @(posedge sys_clk);
    #1;
    chk("init_pulse", resp_valid, 1'b0);
  endtask

  task automatic run_cmd(input string tag, input logic [5:0] idx,
                         input logic [31:0] arg, input logic [6:0] crc,
                         input logic [2:0] len);
    int p, d, n, lat, base;
    logic found;
    logic [7:0] r1e;
    logic [31:0] de;
    logic [47:0] fr;
    logic [7:0] eb;
    logic [6:0] ce;
    found = 1'b0;
    p = 0;
    r1e = 8'hFF;
    for (int i = 0; i < NCR; i++) begin
      if (!found) begin
        p++;
        if (!reply[i][7]) begin
          found = 1'b1;
          r1e = reply[i];
        end
      end
    end
    d = (found && len != 3'd0 && !r1e[2]) ? 4 : 0;
    de = (d == 4) ? {reply[p], reply[p+1], reply[p+2], reply[p+3]} : 32'd0;
    n = 8 + p + d;
    base = n * 16 * CD;
`ifdef SD_SPI_HOST_CRC7_EN
    ce = crc7({2'b01, idx, arg});
`else
    ce = crc;
`endif
    fr = {2'b01, idx, arg, ce, 1'b1};

    cmd_index = idx;
    cmd_arg = arg;
    cmd_crc = crc;
    resp_len = len;
    cmd_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < base + 200) begin
      // a stray request while busy must be ignored
      if (lat == 100) cmd_valid = 1'b1;
      if (lat == 101) cmd_valid = 1'b0;
      @(posedge sys_clk);
      #1;
      lat++;
    end
    cmd_valid = 1'b0;
    chk({tag, "_valid"}, resp_valid, 1'b1);
    chk({tag, "_lat"}, (lat >= base && lat <= base + 4), 1'b1);
    chk({tag, "_r1"}, resp_r1, r1e);
    chk({tag, "_to"}, resp_timeout, !found);
    chk({tag, "_data"}, resp_data, de);
    chk({tag, "_nbytes"}, mq.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i >= 1 && i <= 6) eb = fr[47 - 8*(i-1) -: 8];
      else eb = 8'hFF;
      chk({tag, "_mosi"}, mq[i], eb);
    end
    chk({tag, "_cs"}, spi_cs_n, 1'b1);
    @(posedge sys_clk);
    #1;
    chk({tag, "_pulse"}, resp_valid, 1'b0);
    chk({tag, "_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int lead;
    fill_ff();
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_sck", spi_sck, 1'b0);
    chk("rst_cs", spi_cs_n, 1'b1);
    chk("rst_mosi", spi_mosi, 1'b1);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_valid", resp_valid, 1'b0);
    chk("rst_r1", resp_r1, 8'hFF);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_to", resp_timeout, 1'b0);
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;

    do_init(1'b0);
    do_init(1'b1);

    fill_ff();
    reply[1] = 8'h01;
    run_cmd("cmd0", 6'd0, 32'd0, 7'h4A, 3'd0);
    chk("cmd0_crc", mq[6], 8'h95);

    fill_ff();
    reply[0] = 8'h01; reply[1] = 8'h00; reply[2] = 8'h00;
    reply[3] = 8'h01; reply[4] = 8'hAA;
    run_cmd("cmd8", 6'd8, 32'h1AA, 7'h43, 3'd4);
    chk("cmd8_crc", mq[6], 8'h87);

    fill_ff();
    run_cmd("tmo", 6'd8, 32'h1AA, 7'h43, 3'd4);

    fill_ff();
    reply[0] = 8'h05; reply[1] = 8'h11; reply[2] = 8'h22;
    reply[3] = 8'h33; reply[4] = 8'h44;
    run_cmd("cmd58", 6'd58, 32'd0, 7'h7E, 3'd4);
    chk("cmd58_crc", mq[6], 8'hFD);

    fill_ff();
    reply[2] = 8'h00; reply[3] = 8'h00;
    run_cmd("cmd13", 6'd13, 32'd0, 7'h06, 3'd1);
    chk("cmd13_crc", mq[6], 8'h0D);

    // reset in the middle of the command frame
    fill_ff();
    reply[1] = 8'h01;
    cmd_index = 6'd0; cmd_arg = 32'd0; cmd_crc = 7'h4A; resp_len = 3'd0;
    cmd_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    cmd_valid = 1'b0;
    repeat (200) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("mrst_cs", spi_cs_n, 1'b1);
    chk("mrst_sck", spi_sck, 1'b0);
    chk("mrst_mosi", spi_mosi, 1'b1);
    chk("mrst_ready", cmd_ready, 1'b1);
    chk("mrst_valid", resp_valid, 1'b0);
    sys_rst = 1'b0;
    seen = 1'b0;
    repeat (1200) begin
      @(posedge sys_clk);
      #1;
      if (resp_valid || !spi_cs_n) seen = 1'b1;
    end
    chk("mrst_quiet", seen, 1'b0);
    run_cmd("cmd0b", 6'd0, 32'd0, 7'h4A, 3'd0);

    for (int t = 0; t < 12; t++) begin
      fill_ff();
      lead = $urandom_range(0, 9);
      for (int i = 0; i < lead; i++) reply[i] = 8'h80 | 8'($urandom);
      reply[lead] = 8'($urandom) & 8'h7F;
      for (int i = 1; i <= 4; i++) reply[lead + i] = 8'($urandom);
      run_cmd("rnd", 6'($urandom), $urandom, 7'($urandom),
              3'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
